// File: rtl/ntt_mod_pkg.sv
// rtl/ntt_mod_pkg.sv - shared modulus table and coefficient helpers for the NTT datapath
package ntt_mod_pkg;

    localparam int COEF_W     = 30;
    localparam int NUM_MODULI = 13;

    // Index 12 and above all resolve to the largest modulus.
    function automatic logic [COEF_W-1:0] q_of(input int mod_index);
        case (mod_index)
            0:       q_of = 30'd1063321601;
            1:       q_of = 30'd1063452673;
            2:       q_of = 30'd1064697857;
            3:       q_of = 30'd1065484289;
            4:       q_of = 30'd1065811969;
            5:       q_of = 30'd1068236801;
            6:       q_of = 30'd1068433409;
            7:       q_of = 30'd1068564481;
            8:       q_of = 30'd1069219841;
            9:       q_of = 30'd1070727169;
            10:      q_of = 30'd1071513601;
            11:      q_of = 30'd1072496641;
            default: q_of = 30'd1073479681;
        endcase
    endfunction

    // Modular subtract used by the subtractor datapath; operands assumed < q.
    function automatic logic [COEF_W-1:0] mod_sub(input logic [COEF_W-1:0] a,
                                                  input logic [COEF_W-1:0] b,
                                                  input logic [COEF_W-1:0] q);
        mod_sub = (a >= b) ? (a - b) : (a + (q - b));
    endfunction

endpackage

// File: rtl/mod_reduce_once.sv
// rtl/mod_reduce_once.sv - conditional single subtraction of Q from a 31-bit sum
module mod_reduce_once
    import ntt_mod_pkg::*;
#(
    parameter logic [COEF_W-1:0] Q = 30'd1063321601
) (
    input  logic [COEF_W:0]   sum,
    output logic [COEF_W-1:0] c
);

    // sum < 2^31 and the reduced result fits in 30 bits, so the low bits suffice.
    logic [COEF_W-1:0] diff;

    assign diff = sum[COEF_W-1:0] - Q;
    assign c    = (sum >= {1'b0, Q}) ? diff : sum[COEF_W-1:0];

endmodule

// File: rtl/poly_modular_adder.sv
// rtl/poly_modular_adder.sv - two-stage streaming (a + b) mod Q with block framing
module poly_modular_adder
    import ntt_mod_pkg::*;
#(
    parameter int MOD_INDEX = 0,
    parameter int N         = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_a,
    input  logic [COEF_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] out_c,
    output logic              out_last,
    output logic              range_err
);

    localparam logic [COEF_W-1:0] Q        = q_of(MOD_INDEX);
    localparam int                CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

    logic              adv;
    logic              xfer;
    logic [CNT_W-1:0]  count;
    logic [COEF_W:0]   s1_sum;
    logic              s1_last;
    logic              s1_valid;
    logic [COEF_W-1:0] s2_c;
    logic              s2_last;
    logic              s2_valid;
    logic [COEF_W-1:0] reduced;
    logic              range_err_q;

    // Single global enable: the whole pipe moves or holds together.
    assign adv      = !s2_valid || out_ready;
    assign xfer     = in_valid && adv;
    assign in_ready = adv;

    mod_reduce_once #(.Q(Q)) u_reduce (
        .sum (s1_sum),
        .c   (reduced)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            s1_sum      <= '0;
            s1_last     <= 1'b0;
            s1_valid    <= 1'b0;
            s2_c        <= '0;
            s2_last     <= 1'b0;
            s2_valid    <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            if (xfer) begin
                count <= (count == CNT_LAST) ? '0 : count + 1'b1;
                if ((in_a >= Q) || (in_b >= Q)) begin
                    range_err_q <= 1'b1;
                end
            end
            if (adv) begin
                s1_sum   <= {1'b0, in_a} + {1'b0, in_b};
                s1_last  <= xfer && (count == CNT_LAST);
                s1_valid <= xfer;
                s2_c     <= reduced;
                s2_last  <= s1_last;
                s2_valid <= s1_valid;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_c     = s2_c;
    assign out_last  = s2_last;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_poly_modular_adder.sv
// tb/tb_poly_modular_adder.sv - self-checking bench for poly_modular_adder
module tb_poly_modular_adder;

    localparam longint Q0  = 64'd1063321601;
    localparam longint Q12 = 64'd1073479681;
    localparam int     NB  = 4;

    typedef struct {
        logic [29:0] a;
        logic [29:0] b;
        logic [29:0] c;
    } vec_t;

    typedef struct {
        longint c;
        bit     last;
        bit     dc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] in_a = '0;
    logic [29:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [29:0] out_c;
    logic        out_last;
    logic        range_err;

    logic        v12 = 1'b0;
    logic        rdy12;
    logic [29:0] a12 = '0;
    logic [29:0] b12 = '0;
    logic        ov12;
    logic        or12 = 1'b1;
    logic [29:0] c12;
    logic        last12;
    logic        err12;

    poly_modular_adder #(.MOD_INDEX(0), .N(NB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_last(out_last), .range_err(range_err)
    );

    poly_modular_adder #(.MOD_INDEX(12), .N(NB)) dut12 (
        .clk(clk), .rst(rst), .in_valid(v12), .in_ready(rdy12),
        .in_a(a12), .in_b(b12), .out_valid(ov12), .out_ready(or12),
        .out_c(c12), .out_last(last12), .range_err(err12)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    int          last_pos[$];
    int          in_cnt = 0;
    int          out_idx = 0;
    bit          stall_prev = 1'b0;
    logic [29:0] prev_c = '0;
    logic        prev_last = 1'b0;
    logic        s_ov;
    logic [29:0] s_oc;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [29:0] rnd_op();
        return 30'($urandom_range(32'(Q0 - 1), 0));
    endfunction

    // One clock: drive at negedge, sample 1ns later, score both handshakes.
    task automatic cycle(input logic v, input logic [29:0] a, input logic [29:0] b,
                         input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        chk("in_ready", longint'(in_ready), longint'(!out_valid || ordy));
        if (stall_prev) begin
            chk("stall_valid", longint'(out_valid), 1);
            chk("stall_c", longint'(out_c), longint'(prev_c));
            chk("stall_last", longint'(out_last), longint'(prev_last));
        end
        if (out_valid && ordy) begin
            out_idx++;
            if (out_last) last_pos.push_back(out_idx);
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                if (!e.dc) chk("out_c", longint'(out_c), e.c);
                chk("out_last", longint'(out_last), longint'(e.last));
            end
        end
        acc = v && in_ready;
        if (acc) begin
            e.dc   = (longint'(a) >= Q0) || (longint'(b) >= Q0);
            e.c    = (longint'(a) + longint'(b)) % Q0;
            e.last = (in_cnt % NB) == NB - 1;
            exp_q.push_back(e);
            in_cnt++;
        end
        stall_prev = out_valid && !ordy;
        prev_c     = out_c;
        prev_last  = out_last;
        s_ov       = out_valid;
        s_oc       = out_c;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0, '0, '0, 1'b1, acc);
        chk("drain_left", longint'(exp_q.size()), 0);
        repeat (3) cycle(1'b0, '0, '0, 1'b1, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        logic        acc;
        logic [29:0] pa[3];
        int          idx;
        int          base;
        logic [29:0] qa;

        tbl[0] = '{30'd5, 30'd7, 30'd12};
        tbl[1] = '{30'd1063321600, 30'd1, 30'd0};
        tbl[2] = '{30'd1063321600, 30'd1063321600, 30'd1063321599};
        tbl[3] = '{30'd0, 30'd0, 30'd0};
        tbl[4] = '{30'd500000000, 30'd600000000, 30'd36678399};
        tbl[5] = '{30'd1063321599, 30'd1, 30'd1063321600};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_c", longint'(out_c), 0);
        chk("rst_out_last", longint'(out_last), 0);
        chk("rst_range_err", longint'(range_err), 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);

        // Directed vectors with a two-cycle latency check on each.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, tbl[i].a, tbl[i].b, 1'b1, acc);
            chk("vec_accept", longint'(acc), 1);
            cycle(1'b0, '0, '0, 1'b1, acc);
            chk("vec_lat1_valid", longint'(s_ov), 0);
            cycle(1'b0, '0, '0, 1'b1, acc);
            chk("vec_lat2_valid", longint'(s_ov), 1);
            chk("vec_c", longint'(s_oc), longint'(tbl[i].c));
        end
        drain();

        // Back-pressure: out_ready low for 5 cycles in the middle of the stream.
        pa[0] = 30'd1; pa[1] = 30'd2; pa[2] = 30'd3;
        idx  = 0;
        base = out_idx;
        for (int cyc = 0; cyc < 40 && idx < 3; cyc++) begin
            cycle(1'b1, pa[idx], pa[idx], !(cyc >= 2 && cyc < 7), acc);
            if (acc) idx++;
        end
        chk("bp_sent", longint'(idx), 3);
        drain();
        chk("bp_count", longint'(out_idx - base), 3);

        // Reset with both stages full and the consumer stalled.
        qa = 30'(Q0);
        cycle(1'b1, qa, '0, 1'b0, acc);
        cycle(1'b1, 30'd3, 30'd4, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("pre_rst_err", longint'(range_err), 1);
        chk("pre_rst_full", longint'(out_valid), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_c", longint'(out_c), 0);
        chk("mid_rst_last", longint'(out_last), 0);
        chk("mid_rst_err", longint'(range_err), 0);
        chk("mid_rst_in_ready", longint'(in_ready), 1);
        exp_q.delete();
        last_pos.delete();
        in_cnt     = 0;
        out_idx    = 0;
        stall_prev = 1'b0;

        // Framing: 10 pairs, random consumer readiness.
        idx = 0;
        for (int cyc = 0; cyc < 200 && idx < 10; cyc++) begin
            cycle(1'b1, rnd_op(), rnd_op(), 1'($urandom_range(1, 0)), acc);
            if (acc) idx++;
        end
        chk("frame_sent", longint'(idx), 10);
        drain();
        chk("frame_last_count", longint'(last_pos.size()), 2);
        if (last_pos.size() == 2) begin
            chk("frame_last_0", longint'(last_pos[0]), 4);
            chk("frame_last_1", longint'(last_pos[1]), 8);
        end

        // Random traffic against the scoreboard.
        for (int cyc = 0; cyc < 400; cyc++) begin
            cycle(1'($urandom_range(1, 0)), rnd_op(), rnd_op(), ($urandom_range(3, 0) != 0), acc);
        end
        drain();
        chk("final_range_err", longint'(range_err), 0);

        // Largest modulus: out-of-range flag and wrap.
        @(negedge clk);
        v12 = 1'b1; a12 = 30'(Q12); b12 = '0;
        #1;
        chk("q12_err_before", longint'(err12), 0);
        @(negedge clk);
        a12 = 30'(Q12 - 1); b12 = 30'd2;
        #1;
        chk("q12_err_set", longint'(err12), 1);
        @(negedge clk);
        v12 = 1'b0;
        @(negedge clk);
        #1;
        chk("q12_valid", longint'(ov12), 1);
        chk("q12_c", longint'(c12), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("q12_err_held", longint'(err12), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
